// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, IM read port, IF/ID register, halt detect and drain.
// Optional perf counters (fetch_cnt, stall_cnt) are built when IF_PERF_EN is defined.
module if_stage #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE   = 4'hF,
    parameter logic [15:0] NOP_INSTR    = 16'h0000,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] pc,
    output logic [15:0] im_addr,
    output logic        im_rd_en,
    input  logic [15:0] im_instr,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_inc,
    output logic        ifid_valid,
    output logic        hlt,
    output logic [15:0] fetch_cnt,
    output logic [15:0] stall_cnt
);

    localparam int unsigned XLEN = 16;
    localparam int unsigned CW   = 4;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT_PEND,
        ST_HALTED
    } state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc_q, pc_nxt;
    logic [XLEN-1:0]   instr_q, instr_nxt;
    logic [XLEN-1:0]   pc_inc_q, pc_inc_nxt;
    logic              valid_q, valid_nxt;
    logic              hlt_q, hlt_nxt;
    logic [CW-1:0]     drain_q, drain_nxt;
    logic [XLEN-1:0]   pc_inc;
    logic              rd_en;

    assign pc_inc   = pc_q + XLEN'(1);
    assign rd_en    = (state == ST_RUN) && !stall && !br_taken;

    assign pc          = pc_q;
    assign im_addr     = pc_q;
    assign im_rd_en    = rd_en;
    assign ifid_instr  = instr_q;
    assign ifid_pc_inc = pc_inc_q;
    assign ifid_valid  = valid_q;
    assign hlt         = hlt_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next datapath values; redirect beats stall beats fetch
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc_q;
        instr_nxt  = instr_q;
        pc_inc_nxt = pc_inc_q;
        valid_nxt  = valid_q;
        drain_nxt  = drain_q;
        hlt_nxt    = hlt_q;

        unique case (state)
            ST_RUN: begin
                if (br_taken) begin
                    pc_nxt    = br_target;
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                end else if (!stall) begin
                    instr_nxt  = im_instr;
                    pc_inc_nxt = pc_inc;
                    valid_nxt  = 1'b1;
                    if (im_instr[15:12] == HLT_OPCODE) begin
                        state_nxt = ST_HALT_PEND;
                        drain_nxt = '0;
                    end else begin
                        pc_nxt = pc_inc;
                    end
                end
            end
            ST_HALT_PEND: begin
                // Halt stays speculative until the drain completes
                if (br_taken) begin
                    pc_nxt    = br_target;
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                    drain_nxt = '0;
                    state_nxt = ST_RUN;
                end else if (!stall) begin
                    instr_nxt = NOP_INSTR;
                    valid_nxt = 1'b0;
                    drain_nxt = drain_q + CW'(1);
                    if (drain_q == CW'(DRAIN_CYCLES - 1)) begin
                        state_nxt = ST_HALTED;
                        hlt_nxt   = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                hlt_nxt = 1'b1;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // PC, IF/ID register, drain counter, halt flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pc_inc_q <= '0;
            valid_q  <= 1'b0;
            drain_q  <= '0;
            hlt_q    <= 1'b0;
        end else begin
            pc_q     <= pc_nxt;
            instr_q  <= instr_nxt;
            pc_inc_q <= pc_inc_nxt;
            valid_q  <= valid_nxt;
            drain_q  <= drain_nxt;
            hlt_q    <= hlt_nxt;
        end
    end

`ifdef IF_PERF_EN
    logic [XLEN-1:0] fetch_cnt_q;
    logic [XLEN-1:0] stall_cnt_q;
    logic            stall_hit;

    assign stall_hit = (state == ST_RUN) && stall && !br_taken;

    // Perf counters; wrap naturally, frozen outside RUN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (rd_en) begin
                fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
            end
            if (stall_hit) begin
                stall_cnt_q <= stall_cnt_q + XLEN'(1);
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign fetch_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule
